// File: rtl/debug_watch_unit.sv
// Data-breakpoint matcher: captures one access per cycle, matches it against
// NUM_BP address/type windows, and holds per-slot hits until the access completes.
module debug_watch_unit #(
  parameter int NUM_BP    = 4,
  parameter int ADDR_W    = 32,
  parameter int ACC_LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP*2-1:0]      bp_rw,
  input  logic [NUM_BP*3-1:0]      bp_len,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic                     acc_do,
  input  logic                     acc_write,
  input  logic [ADDR_W-1:0]        acc_address,
  input  logic [ACC_LEN_W-1:0]     acc_length,
  input  logic                     acc_done,
  output logic [NUM_BP-1:0]        hit,
  output logic                     hit_any
);

  logic                 r_cap_valid;
  logic                 r_cap_write;
  logic [ADDR_W-1:0]    r_cap_addr;
  logic [ACC_LEN_W-1:0] r_cap_len;
  logic [NUM_BP-1:0]    r_sticky;

  logic [ADDR_W:0]      w_len_ext;
  logic [ADDR_W:0]      w_sum;
  logic [ADDR_W-1:0]    w_last;
  logic                 w_len_nz;
  logic                 w_wrap;
  logic [NUM_BP-1:0]    w_trig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_valid <= 1'b0;
      r_cap_write <= 1'b0;
      r_cap_addr  <= '0;
      r_cap_len   <= '0;
    end else begin
      r_cap_valid <= acc_do;
      r_cap_write <= acc_write;
      r_cap_addr  <= acc_address;
      r_cap_len   <= acc_length;
    end
  end

  // One extra bit on the end-address add exposes the wrap past the top of memory.
  assign w_len_ext = {{(ADDR_W + 1 - ACC_LEN_W){1'b0}}, r_cap_len};
  assign w_sum     = {1'b0, r_cap_addr} + w_len_ext - {{ADDR_W{1'b0}}, 1'b1};
  assign w_last    = w_sum[ADDR_W-1:0];
  assign w_len_nz  = |r_cap_len;
  assign w_wrap    = w_len_nz & w_sum[ADDR_W];

  for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_slot
    logic [ADDR_W-1:0] w_slot_addr;
    logic [ADDR_W-1:0] w_lo;
    logic [ADDR_W-1:0] w_hi;
    logic [2:0]        w_mask;
    logic [1:0]        w_rw;
    logic              w_type_ok;
    logic              w_overlap;

    assign w_slot_addr = bp_addr[gi*ADDR_W +: ADDR_W];
    assign w_mask      = bp_len[gi*3 +: 3];
    assign w_rw        = bp_rw[gi*2 +: 2];

    // The length mask marks which low slot-address bits are don't-care.
    assign w_lo = {w_slot_addr[ADDR_W-1:3], w_slot_addr[2:0] & ~w_mask};
    assign w_hi = {w_slot_addr[ADDR_W-1:3], w_slot_addr[2:0] |  w_mask};

    assign w_type_ok = (w_rw == 2'b11) || ((w_rw == 2'b01) && r_cap_write);
    assign w_overlap = w_wrap ? ((w_hi >= r_cap_addr) || (w_lo <= w_last))
                              : ((r_cap_addr <= w_hi) && (w_last >= w_lo));

    assign w_trig[gi] = r_cap_valid & bp_en[gi] & w_type_ok & w_len_nz & w_overlap;
  end

  // Completion wins over a same-cycle trigger; the live trigger still shows on hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else if (acc_done) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= r_sticky | w_trig;
    end
  end

  assign hit     = w_trig | r_sticky;
  assign hit_any = |hit;

endmodule

// File: tb/tb_debug_watch_unit.sv
// Scoreboard bench: a byte-level reference model predicts hits for a 4-slot/32-bit
// and an 8-slot/24-bit instance driven by the same access stream.
module tb_debug_watch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc_do = 1'b0;
  logic        acc_write = 1'b0;
  logic [31:0] acc_address = '0;
  logic [3:0]  acc_length = '0;
  logic        acc_done = 1'b0;

  logic [4*32-1:0] bp_addr_a = '0;
  logic [4*2-1:0]  bp_rw_a = '0;
  logic [4*3-1:0]  bp_len_a = '0;
  logic [3:0]      bp_en_a = '0;
  logic [3:0]      hit_a;
  logic            hit_any_a;

  logic [8*24-1:0] bp_addr_b = '0;
  logic [8*2-1:0]  bp_rw_b = '0;
  logic [8*3-1:0]  bp_len_b = '0;
  logic [7:0]      bp_en_b = '0;
  logic [7:0]      hit_b;
  logic            hit_any_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  debug_watch_unit #(.NUM_BP(4), .ADDR_W(32), .ACC_LEN_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .bp_addr(bp_addr_a), .bp_rw(bp_rw_a), .bp_len(bp_len_a), .bp_en(bp_en_a),
    .acc_do(acc_do), .acc_write(acc_write), .acc_address(acc_address),
    .acc_length(acc_length), .acc_done(acc_done),
    .hit(hit_a), .hit_any(hit_any_a)
  );

  debug_watch_unit #(.NUM_BP(8), .ADDR_W(24), .ACC_LEN_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .bp_addr(bp_addr_b), .bp_rw(bp_rw_b), .bp_len(bp_len_b), .bp_en(bp_en_b),
    .acc_do(acc_do), .acc_write(acc_write), .acc_address(acc_address[23:0]),
    .acc_length(acc_length), .acc_done(acc_done),
    .hit(hit_b), .hit_any(hit_any_b)
  );

  // Reference model state: slot configuration and behavioural access/hit state.
  logic [31:0] m_addr [2][8];
  logic [2:0]  m_len  [2][8];
  logic [1:0]  m_rw   [2][8];
  bit          m_en   [2][8];
  bit          c_v [2];
  bit          c_w [2];
  logic [31:0] c_a [2];
  logic [3:0]  c_l [2];
  bit          st  [2][8];

  typedef struct packed {
    logic [3:0] ea;
    logic [7:0] eb;
  } exp_t;
  exp_t exp_q[$];

  function automatic int nslots(int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic logic [31:0] amask(int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
  endfunction

  // Does any byte of the access fall inside the slot's aligned window?
  function automatic bit model_trig(int d, int s, bit cv, bit cw, logic [31:0] ca, logic [3:0] cl);
    logic [31:0] lo, hi, b, lm;
    if (!cv || !m_en[d][s] || cl == 4'd0) return 1'b0;
    if (!(m_rw[d][s] == 2'b11 || (m_rw[d][s] == 2'b01 && cw))) return 1'b0;
    lm = {29'd0, m_len[d][s]};
    lo = m_addr[d][s] & ~lm & amask(d);
    hi = (m_addr[d][s] | lm) & amask(d);
    for (int k = 0; k < int'(cl); k++) begin
      b = (ca + 32'(k)) & amask(d);
      if (b >= lo && b <= hi) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_slot(input int d, input int s, input logic [31:0] a,
                          input logic [2:0] l, input logic [1:0] rw, input bit en);
    m_addr[d][s] = a & amask(d);
    m_len[d][s]  = l;
    m_rw[d][s]   = rw;
    m_en[d][s]   = en;
  endtask

  task automatic clear_bp();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 8; s++) set_slot(d, s, 32'd0, 3'd0, 2'd0, 1'b0);
  endtask

  task automatic drive_bp();
    for (int s = 0; s < 4; s++) begin
      bp_addr_a[s*32 +: 32] = m_addr[0][s];
      bp_len_a[s*3 +: 3]    = m_len[0][s];
      bp_rw_a[s*2 +: 2]     = m_rw[0][s];
      bp_en_a[s]            = m_en[0][s];
    end
    for (int s = 0; s < 8; s++) begin
      bp_addr_b[s*24 +: 24] = m_addr[1][s][23:0];
      bp_len_b[s*3 +: 3]    = m_len[1][s];
      bp_rw_b[s*2 +: 2]     = m_rw[1][s];
      bp_en_b[s]            = m_en[1][s];
    end
  endtask

  // Called just after a falling edge with inputs set; predicts the hit seen after the next rise.
  task automatic step();
    exp_t e;
    e = '0;
    drive_bp();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        c_v[d] = 1'b0; c_w[d] = 1'b0; c_a[d] = '0; c_l[d] = '0;
        for (int s = 0; s < 8; s++) st[d][s] = 1'b0;
      end else begin
        for (int s = 0; s < nslots(d); s++) begin
          if (acc_done) st[d][s] = 1'b0;
          else if (model_trig(d, s, c_v[d], c_w[d], c_a[d], c_l[d])) st[d][s] = 1'b1;
        end
        c_v[d] = acc_do;
        c_w[d] = acc_write;
        c_a[d] = acc_address & amask(d);
        c_l[d] = acc_length;
      end
      for (int s = 0; s < nslots(d); s++) begin
        if (model_trig(d, s, c_v[d], c_w[d], c_a[d], c_l[d]) || st[d][s]) begin
          if (d == 0) e.ea[s] = 1'b1;
          else        e.eb[s] = 1'b1;
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic access(input logic [31:0] a, input logic [3:0] l, input bit w, input int n);
    acc_do = 1'b1; acc_address = a; acc_length = l; acc_write = w;
    repeat (n) step();
    acc_do = 1'b0;
  endtask

  task automatic idle(input int n);
    acc_do = 1'b0;
    repeat (n) step();
  endtask

  task automatic complete();
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] base;
    case ($urandom_range(0, 2))
      0:       base = 32'h0000_1000;
      1:       base = 32'h0000_2000;
      default: base = 32'hFFFF_FFF8;
    endcase
    return base + 32'($urandom_range(0, 20)) - 32'd6;
  endfunction

  task automatic random_bp();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < nslots(d); s++)
        set_slot(d, s, pick_addr(), 3'(( 1 << $urandom_range(0, 3)) - 1),
                 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
  endtask

  // Monitor: hit is presented every cycle; compare after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hit_a", 32'(hit_a), 32'(e.ea));
        chk("hit_any_a", 32'(hit_any_a), 32'(|e.ea));
        chk("hit_b", 32'(hit_b), 32'(e.eb));
        chk("hit_any_b", 32'(hit_any_b), 32'(|e.eb));
      end
    end
  end

  initial begin
    clear_bp();
    for (int d = 0; d < 2; d++) begin
      c_v[d] = 1'b0; c_w[d] = 1'b0; c_a[d] = '0; c_l[d] = '0;
      for (int s = 0; s < 8; s++) st[d][s] = 1'b0;
    end
    @(negedge clk);
    chk("reset_hit", 32'(hit_a), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Read inside a 4-byte slot; held until completion.
    set_slot(0, 0, 32'h1000, 3'b011, 2'b11, 1'b1);
    access(32'h1002, 4'd4, 1'b0, 2);
    idle(3);
    chk("sticky_hold", 32'(hit_a), 32'h1);
    complete();
    idle(1);
    chk("cleared", 32'(hit_a), 32'h0);

    // Write-only slot.
    clear_bp();
    set_slot(0, 1, 32'h2000, 3'b000, 2'b01, 1'b1);
    access(32'h2000, 4'd1, 1'b0, 2);
    chk("wr_slot_read", 32'(hit_a), 32'h0);
    complete();
    access(32'h2000, 4'd1, 1'b1, 2);
    chk("wr_slot_write", 32'(hit_a), 32'h2);
    complete();

    // Access wrapping past the top of the address space.
    clear_bp();
    set_slot(0, 2, 32'h0, 3'b000, 2'b11, 1'b1);
    access(32'hFFFF_FFFE, 4'd4, 1'b0, 2);
    chk("wrap_hit", 32'(hit_a), 32'h4);
    complete();
    set_slot(0, 2, 32'h10, 3'b000, 2'b11, 1'b1);
    access(32'hFFFF_FFFE, 4'd4, 1'b0, 2);
    chk("wrap_miss", 32'(hit_a), 32'h0);
    complete();

    // Window edges and zero length.
    clear_bp();
    set_slot(0, 3, 32'h3004, 3'b011, 2'b11, 1'b1);
    access(32'h3000, 4'd4, 1'b0, 2);
    chk("edge_below", 32'(hit_a), 32'h0);
    complete();
    access(32'h3001, 4'd4, 1'b0, 2);
    chk("edge_touch", 32'(hit_a), 32'h8);
    complete();
    access(32'h3004, 4'd0, 1'b0, 2);
    chk("zero_len", 32'(hit_a), 32'h0);
    complete();

    // Completion in the same cycle as the trigger.
    clear_bp();
    set_slot(0, 0, 32'h1000, 3'b011, 2'b11, 1'b1);
    access(32'h1000, 4'd2, 1'b0, 1);
    acc_done = 1'b1;
    chk("done_same_cycle", 32'(hit_a), 32'h1);
    step();
    acc_done = 1'b0;
    chk("done_next_cycle", 32'(hit_a), 32'h0);

    // Asynchronous reset while a hit is held.
    access(32'h1001, 4'd1, 1'b0, 2);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(hit_a), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("after_reset", 32'(hit_a), 32'h0);

    // Eight-slot, 24-bit instance: first and last slot on one access.
    clear_bp();
    set_slot(1, 0, 32'h400, 3'b111, 2'b11, 1'b1);
    set_slot(1, 7, 32'h404, 3'b000, 2'b11, 1'b1);
    access(32'h403, 4'd4, 1'b1, 2);
    chk("wide_hit", 32'(hit_b), 32'h81);
    chk("wide_any", 32'(hit_any_b), 32'h1);
    complete();

    // Randomised traffic.
    random_bp();
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) random_bp();
      acc_address = pick_addr();
      acc_length  = 4'($urandom_range(0, 15));
      acc_write   = 1'($urandom_range(0, 1));
      acc_do      = 1'b1;
      acc_done    = ($urandom_range(0, 3) == 0);
      step();
      acc_done    = ($urandom_range(0, 3) == 0);
      step();
      acc_do      = 1'($urandom_range(0, 1));
      acc_done    = ($urandom_range(0, 2) == 0);
      step();
    end
    acc_done = 1'b0;
    idle(2);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
